board_tx_sequencer: RTL and testbench
=====================================

Name: board_tx_sequencer

Overview:
Sequences transmission of the 208-bit UART-framed board image (81 cells × 2 bits, packed as 21 bytes with embedded stop/start pairs) out of a single serial TX pin. Sits between the board-state logic, which presents the framed bus and raises a send request, and the FPGA UART TX pin. Captures a snapshot of the bus, shifts it out at the baud rate, and holds at most one pending request received while busy.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
GAP_BITS, 10, idle-high bit times inserted after each transmission; legal range ≥ 0.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset; synchronous, active-low
send_req_in  input  1  single-cycle send request
board_bus_in  input  208  framed board bus; bit 0 is transmitted first
busy_out  output  1  high from the cycle after acceptance until GAP completes
done_out  output  1  one-cycle pulse when the trailing stop bit completes
pending_out  output  1  a request is queued behind the current transmission
tx_out  output  1  serial line; idles high

Behaviour:
- Reset (rst_n_in low at a clock edge):
  - State goes to IDLE.
  - Outputs: tx_out=1, busy_out=0, done_out=0, pending_out=0.
  - All counters are cleared and the shift register is cleared.
  - Reset mid-transmission aborts it immediately; tx_out returns high on the next cycle.
- FSM states:
  - IDLE → START when send_req_in=1 or pending=1. On this transition:
    - shift_reg is loaded from board_bus_in.
    - pending is cleared.
  - START: tx_out=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx_out=shift_reg[0] for each bit time; shift right by 1 at each bit boundary. After 208 bits → STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. done_out pulses in the final cycle. Then:
    - → GAP if GAP_BITS>0.
    - → IDLE if GAP_BITS=0.
  - GAP: tx_out=1 for GAP_BITS×CLKS_PER_BIT cycles → IDLE.
- Total line time per transmission is 210 bit times: leading start bit, 208 data bits, trailing stop bit. This yields exactly 21 valid 8N1 frames.
- Latency: tx_out falls in the cycle after send_req_in is sampled in IDLE.
- Snapshot rule: board_bus_in is sampled only on the IDLE→START transition. A pending request transmits the bus value present at that later transition, not the value present when the request arrived.
- Requests while not IDLE set pending. Further requests while pending=1 are coalesced (no counting).
- A request in the same cycle that IDLE consumes pending is absorbed by that transmission.
- busy_out=1 in every state except IDLE.
- After GAP, a set pending starts START on the next cycle, with one IDLE cycle between.
- Baud counter width is $clog2(CLKS_PER_BIT); bit counter width is 8 bits (0..207). Gap counter is sized for GAP_BITS×CLKS_PER_BIT.
- No counter may wrap: each is compared to its terminal value minus 1, then cleared.

Decomposition:
- Package board_pkg holds:
  - BOARD_CELLS=81
  - BOARD_BUS_W=162
  - FRAMED_BUS_W=208
  - TX_BITS=210
  - typedef tx_state_t {IDLE, START, DATA, STOP, GAP}
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT, inputs clk_in/rst_n_in/clear) outputs a one-cycle bit-boundary tick. The FSM clears it on every state entry.

Test Plan:
1. Reset/idle: hold rst_n_in=0 for 3 cycles, then release with no request. Required: tx_out=1, busy_out=0, done_out=0 and pending_out=0 throughout.
2. Single send: CLKS_PER_BIT=4, GAP_BITS=2, board_bus_in=208'h00_01_5...A5 (alternating pattern), one request pulse. Required:
   - tx_out low for 4 cycles.
   - The 208 bits appear LSB first, 4 cycles each.
   - tx_out high for 4 cycles, with done_out pulsed once at cycle 4+832+4.
   - busy_out drops after a further 8 cycles.
3. UART decode: feed a real framed bus for an empty board with one black stone at cell [0][0] into a reference 8N1 receiver model. Required: exactly 21 bytes decoded, byte0=8'h01, bytes1..20=8'h00, and no framing errors.
4. Pending/snapshot: request, then change board_bus_in and issue 3 further requests mid-DATA. Required:
   - pending_out=1; only one extra transmission occurs.
   - It carries the bus value present at its START, with exactly one IDLE cycle after GAP.
5. Reset mid-operation: assert rst_n_in=0 at bit 100 of DATA. Required: next cycle tx_out=1, busy_out=0, pending_out=0, and no done_out pulse.
6. GAP_BITS=0 edge: two back-to-back sends. Required: the second START begins exactly 2 cycles after the first done_out (STOP end plus one IDLE cycle).

Source files
------------

// File: rtl/board_pkg.sv
// Shared sizes and state encoding for the board image serial transmitter.
package board_pkg;

    localparam int unsigned BOARD_CELLS  = 81;
    localparam int unsigned BOARD_BUS_W  = 2 * BOARD_CELLS;
    localparam int unsigned FRAME_BYTES  = (BOARD_BUS_W + 7) / 8;
    localparam int unsigned FRAMED_BUS_W = 8 * FRAME_BYTES + 2 * (FRAME_BYTES - 1);
    localparam int unsigned TX_BITS      = FRAMED_BUS_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time divider: flags the last cycle of each bit and the cycle before it.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_tick_c = (cnt == CNT_W'(CLKS_PER_BIT - 2));

    // Cycle counter within a bit; restarts on clear or at the terminal count.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/board_tx_sequencer.sv
// Snapshots the framed board bus and shifts it out LSB first with start/stop bits and an idle gap.
module board_tx_sequencer
    import board_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned GAP_BITS     = 10
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    send_req_in,
    input  logic [FRAMED_BUS_W-1:0] board_bus_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    pending_out,
    output logic                    tx_out
);

    localparam int unsigned GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int unsigned GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
    localparam int unsigned BIT_W    = 8;
    localparam int unsigned BIT_LAST = FRAMED_BUS_W - 1;

    tx_state_t               state, state_next;
    logic [FRAMED_BUS_W-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]        bit_cnt, bit_next;
    logic [GAP_W-1:0]        gap_cnt, gap_next;
    logic                    pending, pending_next;
    logic                    tx_next, busy_next, done_next;
    logic                    tick_c, pre_tick_c, baud_clear_c;

    assign pending_out  = pending;
    assign baud_clear_c = (state_next != state);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clear     (baud_clear_c),
        .tick_c    (tick_c),
        .pre_tick_c(pre_tick_c)
    );

    // State, datapath and registered line outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            pending   <= 1'b0;
            tx_out    <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
            gap_cnt   <= gap_next;
            pending   <= pending_next;
            tx_out    <= tx_next;
            busy_out  <= busy_next;
            done_out  <= done_next;
        end
    end

    // Next-state, counters, request queueing; outputs decoded from the next state so they align with it.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_next     = bit_cnt;
        gap_next     = '0;
        pending_next = pending;
        done_next    = 1'b0;

        if (state != IDLE && send_req_in) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (send_req_in || pending) begin
                    state_next   = START;
                    shift_next   = board_bus_in;
                    pending_next = 1'b0;
                end
            end
            START: begin
                if (tick_c) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick_c) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == BIT_W'(BIT_LAST)) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                done_next = pre_tick_c;
                if (tick_c) begin
                    state_next = (GAP_BITS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_board_tx_sequencer.sv
// Directed bench: dut_a uses 4 clocks/bit with a 2-bit gap, dut_b uses 4 clocks/bit with no gap.
module tb_board_tx_sequencer;

    localparam int CPB     = 4;
    localparam int GAP_A   = 2 * CPB;
    localparam int FRAME_C = CPB * 210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_a = 1'b0, req_b = 1'b0;
    logic [207:0] bus_a = '0, bus_b = '0;
    logic         busy_a, done_a, pend_a, tx_a;
    logic         busy_b, done_b, pend_b, tx_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    board_tx_sequencer #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut_a (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .send_req_in (req_a),
        .board_bus_in(bus_a),
        .busy_out    (busy_a),
        .done_out    (done_a),
        .pending_out (pend_a),
        .tx_out      (tx_a)
    );

    board_tx_sequencer #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_b (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .send_req_in (req_b),
        .board_bus_in(bus_b),
        .busy_out    (busy_b),
        .done_out    (done_b),
        .pending_out (pend_b),
        .tx_out      (tx_b)
    );

    // Expected {tx,busy,done} at cycle c of a transmission whose START is cycle 1.
    function automatic logic [2:0] exp_line(input int c, input logic [207:0] v, input int gap_clks);
        if (c < 1)                 return 3'b100;
        if (c <= CPB)              return 3'b010;
        if (c <= CPB + 208 * CPB)  return {v[(c - CPB - 1) / CPB], 2'b10};
        if (c <= FRAME_C)          return {2'b11, (c == FRAME_C)};
        if (c <= FRAME_C + gap_clks) return 3'b110;
        return 3'b100;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({tx_a, busy_a, done_a, pend_a, tx_b, busy_b, done_b, pend_b} !== 8'b1000_1000) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d got %b exp 10001000", i,
                         {tx_a, busy_a, done_a, pend_a, tx_b, busy_b, done_b, pend_b});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({tx_a, busy_a, done_a, pend_a, tx_b, busy_b, done_b, pend_b} !== 8'b1000_1000) begin
                miscompares++;
                $display("FAIL reset_idle i=%0d got %b exp 10001000", i,
                         {tx_a, busy_a, done_a, pend_a, tx_b, busy_b, done_b, pend_b});
            end
        end
    endtask

    task automatic test_single_send();
        logic [207:0] pat;
        logic [2:0]   e;
        pat   = {26{8'hA5}};
        bus_a = pat;
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int c = 1; c <= FRAME_C + GAP_A + 4; c++) begin
            e = exp_line(c, pat, GAP_A);
            vectors++;
            if ({tx_a, busy_a, done_a, pend_a} !== {e, 1'b0}) begin
                miscompares++;
                $display("FAIL single c=%0d {tx,busy,done,pend} got %b exp %b", c,
                         {tx_a, busy_a, done_a, pend_a}, {e, 1'b0});
            end
            step();
        end
    endtask

    task automatic test_uart_decode();
        logic [207:0] bus;
        logic         line [0:FRAME_C+19];
        logic [7:0]   rx [0:20];
        logic [7:0]   b;
        int           idx, nbytes, ferr;
        bus = '0;
        for (int i = 0; i < 21; i++) begin
            bus[i*10 +: 8] = (i == 0) ? 8'h01 : 8'h00;
            if (i < 20) begin
                bus[i*10 + 8] = 1'b1;
                bus[i*10 + 9] = 1'b0;
            end
        end
        for (int i = 0; i < 21; i++) rx[i] = 8'hFF;
        bus_a = bus;
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int c = 0; c < FRAME_C + 20; c++) begin
            line[c] = tx_a;
            step();
        end
        idx = 0; nbytes = 0; ferr = 0;
        while (idx < FRAME_C + 20) begin
            if (line[idx] == 1'b0) begin
                if (idx + 38 >= FRAME_C + 20) begin
                    ferr++;
                    break;
                end
                if (line[idx + 2] != 1'b0) ferr++;
                for (int k = 0; k < 8; k++) b[k] = line[idx + 2 + CPB * (k + 1)];
                if (line[idx + 38] != 1'b1) ferr++;
                if (nbytes < 21) rx[nbytes] = b;
                nbytes++;
                idx += 39;
            end else begin
                idx++;
            end
        end
        vectors++;
        if (nbytes !== 21) begin
            miscompares++;
            $display("FAIL uart_count got %0d exp 21", nbytes);
        end
        vectors++;
        if (ferr !== 0) begin
            miscompares++;
            $display("FAIL uart_framing got %0d errors exp 0", ferr);
        end
        vectors++;
        if (rx[0] !== 8'h01) begin
            miscompares++;
            $display("FAIL uart_byte0 got %h exp 01", rx[0]);
        end
        for (int i = 1; i < 21; i++) begin
            vectors++;
            if (rx[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL uart_byte%0d got %h exp 00", i, rx[i]);
            end
        end
    endtask

    task automatic test_pending();
        logic [207:0] p1, p2, p3;
        logic [2:0]   e;
        logic         ep;
        p1 = {13{16'hC3A5}};
        p2 = ~p1;
        p3 = {26{8'h69}};
        bus_a = p1;
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int c = 1; c <= 2 * (FRAME_C + GAP_A) + 1 + 20; c++) begin
            if (c <= FRAME_C + GAP_A)          e = exp_line(c, p1, GAP_A);
            else if (c == FRAME_C + GAP_A + 1) e = 3'b100;
            else                               e = exp_line(c - (FRAME_C + GAP_A + 1), p3, GAP_A);
            ep = (c > 100 && c <= FRAME_C + GAP_A + 1);
            vectors++;
            if ({tx_a, busy_a, done_a, pend_a} !== {e, ep}) begin
                miscompares++;
                $display("FAIL pending c=%0d {tx,busy,done,pend} got %b exp %b", c,
                         {tx_a, busy_a, done_a, pend_a}, {e, ep});
            end
            if (c == 50) bus_a = p2;
            if (c == FRAME_C + GAP_A - 3) bus_a = p3;
            req_a = (c == 100 || c == 200 || c == 300);
            step();
        end
        req_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [207:0] pat;
        logic [2:0]   e;
        pat   = {13{16'h96E1}};
        bus_a = pat;
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int c = 1; c <= CPB + 100 * CPB + 1; c++) begin
            e = exp_line(c, pat, GAP_A);
            vectors++;
            if ({tx_a, busy_a, done_a} !== e) begin
                miscompares++;
                $display("FAIL rstmid_pre c=%0d {tx,busy,done} got %b exp %b", c, {tx_a, busy_a, done_a}, e);
            end
            req_a = (c == 50);
            if (c < CPB + 100 * CPB + 1) step();
        end
        vectors++;
        if (pend_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pend_before got %b exp 1", pend_a);
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if ({tx_a, busy_a, done_a, pend_a} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rstmid_after {tx,busy,done,pend} got %b exp 1000", {tx_a, busy_a, done_a, pend_a});
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < FRAME_C + GAP_A + 20; c++) begin
            step();
            vectors++;
            if ({tx_a, busy_a, done_a, pend_a} !== 4'b1000) begin
                miscompares++;
                $display("FAIL rstmid_quiet c=%0d {tx,busy,done,pend} got %b exp 1000", c,
                         {tx_a, busy_a, done_a, pend_a});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [207:0] q1, q2;
        logic [2:0]   e;
        logic         ep;
        int           first_done, second_start;
        q1 = {26{8'h5A}};
        q2 = {13{16'h0FF0}};
        first_done = -100;
        second_start = -1;
        bus_b = q1;
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        for (int c = 1; c <= 2 * FRAME_C + 1 + 20; c++) begin
            if (c <= FRAME_C)          e = exp_line(c, q1, 0);
            else if (c == FRAME_C + 1) e = 3'b100;
            else                       e = exp_line(c - (FRAME_C + 1), q2, 0);
            ep = (c > 100 && c <= FRAME_C + 1);
            vectors++;
            if ({tx_b, busy_b, done_b, pend_b} !== {e, ep}) begin
                miscompares++;
                $display("FAIL gap0 c=%0d {tx,busy,done,pend} got %b exp %b", c,
                         {tx_b, busy_b, done_b, pend_b}, {e, ep});
            end
            if (done_b === 1'b1 && first_done < 0) first_done = c;
            if (first_done > 0 && second_start < 0 && tx_b === 1'b0) second_start = c;
            if (c == 600) bus_b = q2;
            req_b = (c == 100 || c == FRAME_C + 1);
            step();
        end
        req_b = 1'b0;
        vectors++;
        if (second_start - first_done !== 2) begin
            miscompares++;
            $display("FAIL gap0_spacing got %0d cycles exp 2 (done=%0d start=%0d)",
                     second_start - first_done, first_done, second_start);
        end
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_uart_decode();
        test_pending();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
